// File: rtl/imem_fetch_ctrl.sv
// Fetch sequencer: owns the PC, addresses a combinational instruction ROM and registers
// each instruction into a valid/ready output stage. Define FETCH_BOUNDS_CHECK_EN to trap bad fetches.
module imem_fetch_ctrl #(
   parameter int          MEM_SIZE = 1024,
   parameter logic [63:0] RESET_PC = 64'd0
) (
   input  logic        clk,
   input  logic        reset,
   output logic [63:0] imem_addr,
   input  logic [31:0] imem_instr,
   input  logic        redirect_valid,
   input  logic [63:0] redirect_target,
   input  logic        halt_req,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic [63:0] out_pc,
   output logic [31:0] fetch_count,
   output logic        fault
);

   typedef enum logic [1:0] {IDLE, FETCH, HALTED, FAULT} state_t;

   state_t      state, state_nxt;
   logic [63:0] pc, pc_seq, pc_redir;
   logic        bad_pc, load, take_redirect, handshake;

`ifdef FETCH_BOUNDS_CHECK_EN
   logic fault_q;

   assign bad_pc    = (pc[1:0] != 2'b00) || ((pc + 64'd3) >= 64'(MEM_SIZE));
   assign pc_seq    = pc + 64'd4;
   assign pc_redir  = redirect_target;
   assign imem_addr = pc;
   assign fault     = fault_q;

   always_ff @(posedge clk) begin
      if (reset)
         fault_q <= 1'b0;
      else if (state_nxt == FAULT)
         fault_q <= 1'b1;
   end
`else
   // Without bounds checking the PC lives inside the ROM and wraps around its end.
   localparam logic [63:0] WRAP_MASK = 64'(MEM_SIZE) - 64'd1;
   localparam logic [63:0] WORD_MASK = 64'(MEM_SIZE) - 64'd4;

   assign bad_pc    = 1'b0;
   assign pc_seq    = (pc + 64'd4) & WRAP_MASK;
   assign pc_redir  = redirect_target & WORD_MASK;
   assign imem_addr = pc & WORD_MASK;
   assign fault     = 1'b0;
`endif

   assign handshake = out_valid && out_ready;

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (reset)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      // NOTE: defaults first; every path assigns every output, so no latch is inferred.
      state_nxt     = state;
      load          = 1'b0;
      take_redirect = 1'b0;
      case (state)
         IDLE: begin
            state_nxt     = FETCH;
            take_redirect = redirect_valid;
         end
         FETCH: begin
            if (redirect_valid)
               take_redirect = 1'b1;
            else if (halt_req)
               state_nxt = HALTED;
            else if (bad_pc)
               state_nxt = FAULT;
            else
               load = !out_valid || out_ready;
         end
         HALTED: begin
            if (redirect_valid) begin
               take_redirect = 1'b1;
               state_nxt     = FETCH;
            end else if (!halt_req) begin
               state_nxt = FETCH;
            end
         end
         FAULT:   state_nxt = FAULT;
         default: state_nxt = IDLE;
      endcase
   end

   // A redirect discards whatever sits in the output stage, even if it is being accepted.
   always_ff @(posedge clk) begin
      if (reset) begin
         pc          <= RESET_PC;
         out_valid   <= 1'b0;
         out_instr   <= 32'd0;
         out_pc      <= 64'd0;
         fetch_count <= 32'd0;
      end else begin
         if (handshake)
            fetch_count <= fetch_count + 32'd1;
         if (take_redirect) begin
            pc        <= pc_redir;
            out_valid <= 1'b0;
         end else if (load) begin
            out_instr <= imem_instr;
            out_pc    <= pc;
            out_valid <= 1'b1;
            pc        <= pc_seq;
         end else if (handshake) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Bench for imem_fetch_ctrl: directed scenarios plus random traffic, all checked each cycle
// against a behavioural model of the fetch rules. Honours FETCH_BOUNDS_CHECK_EN.
module tb_imem_fetch_ctrl;

   localparam logic [63:0] MEM    = 64'd1024;
   localparam logic [63:0] RST_PC = 64'd0;

   logic        clk;
   logic        reset;
   logic [63:0] imem_addr;
   logic [31:0] imem_instr;
   logic        redirect_valid;
   logic [63:0] redirect_target;
   logic        halt_req;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [63:0] out_pc;
   logic [31:0] fetch_count;
   logic        fault;

   imem_fetch_ctrl #(.MEM_SIZE(1024), .RESET_PC(64'd0)) dut (
      .clk             (clk),
      .reset           (reset),
      .imem_addr       (imem_addr),
      .imem_instr      (imem_instr),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .halt_req        (halt_req),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .out_instr       (out_instr),
      .out_pc          (out_pc),
      .fetch_count     (fetch_count),
      .fault           (fault)
   );

   // ROM word i holds the value i.
   assign imem_instr = 32'(imem_addr >> 2);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s cycle=%0d got=%h expected=%h", tag, cyc, got, exp);
      end
   endtask

   // Behavioural model: phase 0 idle, 1 fetching, 2 halted, 3 faulted.
   int          m_phase;
   bit          m_known = 1'b0;
   bit          m_valid, m_fault;
   logic [63:0] m_pc, m_opc;
   logic [31:0] m_oins, m_cnt;

   function automatic logic [63:0] addr_of(input logic [63:0] p);
`ifdef FETCH_BOUNDS_CHECK_EN
      return p;
`else
      return (p % MEM) & ~64'd3;
`endif
   endfunction

   function automatic logic [63:0] next_pc(input logic [63:0] p);
`ifdef FETCH_BOUNDS_CHECK_EN
      return p + 64'd4;
`else
      return (p + 64'd4) % MEM;
`endif
   endfunction

   function automatic logic [63:0] redir_pc(input logic [63:0] t);
`ifdef FETCH_BOUNDS_CHECK_EN
      return t;
`else
      return (t & ~64'd3) % MEM;
`endif
   endfunction

   function automatic bit is_bad(input logic [63:0] p);
`ifdef FETCH_BOUNDS_CHECK_EN
      return ((p % 4) != 0) || ((p + 64'd3) >= MEM);
`else
      return 1'b0;
`endif
   endfunction

   task automatic model_step(input bit r, input bit rv, input logic [63:0] t, input bit h, input bit rd);
      if (r) begin
         m_phase = 0; m_pc = RST_PC; m_valid = 0; m_opc = 0; m_oins = 0;
         m_cnt = 0; m_fault = 0; m_known = 1;
         return;
      end
      if (m_valid && rd) begin
         m_cnt++;
         m_valid = 0;
      end
      if (rv && m_phase != 3) begin
         m_pc    = redir_pc(t);
         m_valid = 0;
         m_phase = 1;
         return;
      end
      case (m_phase)
         0: m_phase = 1;
         2: if (!h) m_phase = 1;
         1: begin
            if (h) m_phase = 2;
            else if (is_bad(m_pc)) begin
               m_phase = 3;
               m_fault = 1;
            end else if (!m_valid) begin
               m_oins  = 32'(addr_of(m_pc) >> 2);
               m_opc   = m_pc;
               m_valid = 1;
               m_pc    = next_pc(m_pc);
            end
         end
         default: ;
      endcase
   endtask

   task automatic compare_all();
      check("imem_addr", imem_addr, addr_of(m_pc));
      check("out_valid", out_valid, m_valid);
      check("out_pc", out_pc, m_opc);
      check("out_instr", out_instr, m_oins);
      check("fetch_count", fetch_count, m_cnt);
      check("fault", fault, m_fault);
   endtask

   // One clock: compare current state, drive inputs, advance the model, move to next negedge.
   task automatic tick(input bit r, input bit rv, input logic [63:0] t, input bit h, input bit rd);
      if (m_known) compare_all();
      reset = r; redirect_valid = rv; redirect_target = t; halt_req = h; out_ready = rd;
      model_step(r, rv, t, h, rd);
      @(posedge clk);
      @(negedge clk);
      cyc = r ? 0 : cyc + 1;
   endtask

   task automatic run(input int n, input bit h, input bit rd);
      for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 64'd0, h, rd);
   endtask

   task automatic do_reset();
      tick(1'b1, 1'b0, 64'd0, 1'b0, 1'b1);
      tick(1'b1, 1'b0, 64'd0, 1'b0, 1'b1);
   endtask

   initial begin
      reset = 1'b1; redirect_valid = 1'b0; redirect_target = 64'd0;
      halt_req = 1'b0; out_ready = 1'b1;
      @(negedge clk);

      // Reset release and streaming
      do_reset();
      check("c0_valid", out_valid, 1'b0);
      run(2, 0, 1);
      check("c2_valid", out_valid, 1'b1);
      check("c2_pc", out_pc, RST_PC);
      run(10, 0, 1);
      check("stream_cnt", fetch_count, 32'd10);
      check("stream_pc", out_pc, 64'd40);
      check("stream_ins", out_instr, 32'd10);

      // Backpressure in cycles 3..6
      do_reset();
      run(3, 0, 1);
      check("bp_c3_pc", out_pc, 64'd4);
      check("bp_c3_ins", out_instr, 32'd1);
      run(4, 0, 0);
      check("bp_c7_pc", out_pc, 64'd4);
      check("bp_c7_addr", imem_addr, 64'd8);
      run(1, 0, 1);
      check("bp_c8_pc", out_pc, 64'd8);
      check("bp_c8_ins", out_instr, 32'd2);

      // Redirect in cycle 5
      do_reset();
      run(5, 0, 1);
      tick(1'b0, 1'b1, 64'h40, 1'b0, 1'b1);
      check("rd_cnt", fetch_count, 32'd4);
      check("rd_valid", out_valid, 1'b0);
      check("rd_addr", imem_addr, 64'h40);
      run(1, 0, 1);
      check("rd_pc", out_pc, 64'h40);
      run(1, 0, 1);
      check("rd_pc2", out_pc, 64'h44);

      // Halt in cycles 4..7, then a redirect during a second halt
      do_reset();
      run(4, 0, 1);
      run(4, 1, 1);
      check("hl_drained", out_valid, 1'b0);
      run(2, 0, 1);
      check("hl_resume_pc", out_pc, 64'd12);
      run(2, 0, 1);
      run(1, 1, 1);
      tick(1'b0, 1'b1, 64'h80, 1'b1, 1'b1);
      run(2, 1, 1);
      run(2, 0, 1);
      check("hl_redir_valid", out_valid, 1'b1);
      check("hl_redir_pc", out_pc, 64'h80);

      // Top of ROM
      do_reset();
      run(3, 0, 1);
      tick(1'b0, 1'b1, 64'h3FC, 1'b0, 1'b1);
      run(1, 0, 1);
      check("top_pc", out_pc, 64'h3FC);
      run(1, 0, 1);
`ifdef FETCH_BOUNDS_CHECK_EN
      check("top_fault", fault, 1'b1);
      check("top_valid", out_valid, 1'b0);
      tick(1'b0, 1'b1, 64'h0, 1'b0, 1'b1);
      run(1, 0, 1);
      check("top_ignored_valid", out_valid, 1'b0);
      check("top_ignored_fault", fault, 1'b1);
`else
      check("top_wrap_pc", out_pc, 64'h0);
      check("top_fault", fault, 1'b0);
      tick(1'b0, 1'b1, 64'h402, 1'b0, 1'b1);
      run(1, 0, 1);
      check("top_redir_valid", out_valid, 1'b1);
      check("top_redir_pc", out_pc, 64'h0);
`endif

      // Random traffic
      do_reset();
      for (int i = 0; i < 2500; i++) begin
         bit          r, rv, h, rd;
         logic [63:0] t;
         r  = ($urandom_range(0, 99) == 0);
         rv = ($urandom_range(0, 7) == 0);
         h  = ($urandom_range(0, 5) == 0) ? ~halt_req : halt_req;
         rd = ($urandom_range(0, 3) != 0);
         t  = 64'($urandom_range(0, 260)) * 64'd4;
         if ($urandom_range(0, 7) == 0) t = t + 64'($urandom_range(0, 3));
         tick(r, rv, t, h, rd);
      end
      compare_all();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
